// File: rtl/tri_bus_pkg.sv
// Shared types and helpers for the tri-state bus arbiters.
package tri_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } arb_state_t;

    // Width helper that never collapses to zero bits.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping modulo NREQ.
module rr_pick
    import tri_bus_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int PW  = clog2_safe(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [PW-1:0]   idx
);

    logic [PW:0]   sum;
    logic [PW-1:0] sel;

    // Scan farthest offset first so the nearest candidate is written last.
    always_comb begin
        any = 1'b0;
        idx = '0;
        sum = '0;
        sel = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            sel = sum[PW-1:0];
            if (req[sel]) begin
                any = 1'b1;
                idx = sel;
            end
        end
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner of the output enables on one shared tri1 bus line,
// with a hold limit and a released turnaround between ownerships.
//
// state | meaning
// IDLE  | bus released, waiting for any request
// GRANT | one owner drives, hold counter running
// TURN  | bus released and pulled high before the next ownership
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 4,
    parameter int TURN_CYC = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         drv_en,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy,
    output logic                    turn
);

    localparam int PW = clog2_safe(NREQ);
    localparam int HW = clog2_safe(MAX_HOLD + 1);
    localparam int TW = clog2_safe(TURN_CYC + 1);

    if (TURN_CYC < 1) begin : g_bad_turn
        $error("tri_bus_arbiter: TURN_CYC must be at least 1");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("tri_bus_arbiter: MAX_HOLD must be at least 1");
    end
    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
        $error("tri_bus_arbiter: NREQ must be in 2..16");
    end

    arb_state_t     state, state_n;
    logic [NREQ-1:0] gnt_r, gnt_n;
    logic [PW-1:0]  owner_r, owner_n;
    logic [PW-1:0]  ptr, ptr_n;
    logic [HW-1:0]  hold_cnt, hold_n;
    logic [TW-1:0]  turn_cnt, turn_cnt_n;
    logic           turn_r, turn_n;
    logic           pick_any;
    logic [PW-1:0]  pick_idx;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt_r    <= '0;
            owner_r  <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            turn_cnt <= '0;
            turn_r   <= 1'b0;
        end else begin
            state    <= state_n;
            gnt_r    <= gnt_n;
            owner_r  <= owner_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            turn_cnt <= turn_cnt_n;
            turn_r   <= turn_n;
        end
    end

    always_comb begin
        state_n    = state;
        gnt_n      = gnt_r;
        owner_n    = owner_r;
        ptr_n      = ptr;
        hold_n     = hold_cnt;
        turn_cnt_n = turn_cnt;
        turn_n     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    gnt_n           = '0;
                    gnt_n[pick_idx] = 1'b1;
                    owner_n         = pick_idx;
                    hold_n          = HW'(1);
                    state_n         = GRANT;
                end
            end
            GRANT: begin
                if (req[owner_r] && (hold_cnt < HW'(MAX_HOLD))) begin
                    hold_n = hold_cnt + HW'(1);
                end else begin
                    gnt_n      = '0;
                    ptr_n      = (owner_r == PW'(NREQ - 1)) ? '0 : owner_r + PW'(1);
                    turn_cnt_n = TW'(1);
                    turn_n     = 1'b1;
                    state_n    = TURN;
                end
            end
            TURN: begin
                if (turn_cnt < TW'(TURN_CYC)) begin
                    turn_cnt_n = turn_cnt + TW'(1);
                    turn_n     = 1'b1;
                end else if (pick_any) begin
                    // Pending requests go straight to GRANT; no idle cycle.
                    gnt_n           = '0;
                    gnt_n[pick_idx] = 1'b1;
                    owner_n         = pick_idx;
                    hold_n          = HW'(1);
                    state_n         = GRANT;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign gnt    = gnt_r;
    assign drv_en = gnt_r;
    assign owner  = owner_r;
    assign busy   = |gnt_r;
    assign turn   = turn_r;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter: cycle model feeding a scoreboard queue,
// plus fixed grant-pattern checks, on a tri1 line with four gated drivers.
module tb_tri_bus_arbiter;

    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 4;
    localparam int TURN_CYC = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [3:0] drv_en;
    logic [1:0] owner;
    logic       busy;
    logic       turn;

    tri1 bus_line;

    for (genvar k = 0; k < NREQ; k++) begin : g_drv
        assign bus_line = drv_en[k] ? 1'b0 : 1'bz;
    end

    tri_bus_arbiter #(
        .NREQ     (NREQ),
        .MAX_HOLD (MAX_HOLD),
        .TURN_CYC (TURN_CYC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .gnt    (gnt),
        .drv_en (drv_en),
        .owner  (owner),
        .busy   (busy),
        .turn   (turn)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic       turn;
        logic       bus;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Model state: 0 idle, 1 granted, 2 turnaround.
    int m_st = 0;
    int m_own = 0;
    int m_ptr = 0;
    int m_left = 0;
    int m_tleft = 0;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int d = 0; d < NREQ; d++) begin
            if (r[(p + d) % NREQ]) return (p + d) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r_rst, input logic [3:0] r_req);
        int j;
        if (r_rst) begin
            m_st = 0; m_own = 0; m_ptr = 0;
        end else begin
            case (m_st)
                0: begin
                    j = pick(r_req, m_ptr);
                    if (j >= 0) begin m_st = 1; m_own = j; m_left = MAX_HOLD - 1; end
                end
                1: begin
                    if (r_req[m_own] && m_left > 0) m_left--;
                    else begin
                        m_st = 2; m_ptr = (m_own + 1) % NREQ; m_tleft = TURN_CYC - 1;
                    end
                end
                default: begin
                    if (m_tleft > 0) m_tleft--;
                    else begin
                        j = pick(r_req, m_ptr);
                        if (j >= 0) begin m_st = 1; m_own = j; m_left = MAX_HOLD - 1; end
                        else m_st = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cycle(input logic r_rst, input logic [3:0] r_req);
        exp_t e;
        @(negedge clk);
        rst = r_rst;
        req = r_req;
        model_step(r_rst, r_req);
        e.gnt   = (m_st == 1) ? 4'(1 << m_own) : 4'b0000;
        e.owner = 2'(m_own);
        e.busy  = (m_st == 1);
        e.turn  = (m_st == 2);
        e.bus   = (m_st != 1);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("gnt",     32'(gnt),           32'(e.gnt));
        check("drv_en",  32'(drv_en),        32'(e.gnt));
        check("owner",   32'(owner),         32'(e.owner));
        check("busy",    32'(busy),          32'(e.busy));
        check("turn",    32'(turn),          32'(e.turn));
        check("bus",     32'(bus_line),      32'(e.bus));
        check("bus_x",   32'($isunknown(bus_line)), 32'(0));
        check("onehot0", 32'($onehot0(drv_en)),     32'(1));
    endtask

    initial begin
        logic [3:0] one;
        logic [3:0] expg;
        one = 4'b0001;

        // Reset held with every request high.
        cycle(1'b1, 4'b1111);
        cycle(1'b1, 4'b1111);
        check("rst_gnt",   32'(gnt),   32'(0));
        check("rst_owner", 32'(owner), 32'(0));
        check("rst_turn",  32'(turn),  32'(0));

        // Fairness under continuous full request, starting right at reset release.
        for (int i = 0; i < 21; i++) begin
            cycle(1'b0, 4'b1111);
            expg = ((i % 5) == 4) ? 4'b0000 : (one << ((i / 5) % 4));
            check("fair_gnt",  32'(gnt),  32'(expg));
            check("fair_turn", 32'(turn), 32'((i % 5) == 4));
        end

        // Single requester re-wins after the turnaround.
        cycle(1'b1, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 4'b0100);
            expg = (i == 4 || i == 9) ? 4'b0000 : 4'b0100;
            check("single_gnt", 32'(gnt), 32'(expg));
            check("single_bus", 32'(bus_line), 32'(i == 4 || i == 9));
        end

        // Early release after two cycles.
        cycle(1'b1, 4'b0000);
        cycle(1'b0, 4'b0001);
        cycle(1'b0, 4'b0001);
        check("early_g2", 32'(gnt), 32'(4'b0001));
        cycle(1'b0, 4'b0000);
        check("early_rel_gnt",  32'(gnt),  32'(0));
        check("early_rel_turn", 32'(turn), 32'(1));
        cycle(1'b0, 4'b0000);
        check("early_idle_busy",  32'(busy),  32'(0));
        check("early_idle_turn",  32'(turn),  32'(0));
        check("early_idle_owner", 32'(owner), 32'(0));

        // Request arriving only during the turnaround.
        cycle(1'b1, 4'b0000);
        cycle(1'b0, 4'b0001);
        cycle(1'b0, 4'b0000);
        check("arr_turn", 32'(turn), 32'(1));
        cycle(1'b0, 4'b0010);
        check("arr_gnt",      32'(gnt),  32'(4'b0010));
        check("arr_turn_off", 32'(turn), 32'(0));
        cycle(1'b0, 4'b0000);
        cycle(1'b0, 4'b0000);

        // Reset during owner 2's third cycle, with the pointer already moved to 1.
        cycle(1'b1, 4'b0000);
        cycle(1'b0, 4'b0001);
        cycle(1'b0, 4'b0100);
        cycle(1'b0, 4'b0100);
        check("mid_first", 32'(gnt), 32'(4'b0100));
        cycle(1'b0, 4'b0100);
        cycle(1'b0, 4'b0100);
        check("mid_third", 32'(gnt), 32'(4'b0100));
        cycle(1'b1, 4'b0101);
        check("mid_rst_drv", 32'(drv_en), 32'(0));
        cycle(1'b0, 4'b0101);
        check("mid_next_gnt", 32'(gnt), 32'(4'b0001));
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'b0101);
        check("mid_rr_gnt", 32'(gnt), 32'(4'b0100));

        check("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
